// File: rtl/axi_slave_mem.sv
// AXI4 burst slave backed by byte-lane block RAM with registered reads.
// Read and write FSMs are independent; one outstanding transaction per direction.
module axi_slave_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 8,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                    aclk,
   input  logic                    arstn,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [LEN_WIDTH-1:0]    awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ID_WIDTH-1:0]     bid,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ID_WIDTH-1:0]     arid,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [LEN_WIDTH-1:0]    arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [ID_WIDTH-1:0]     rid,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
   localparam int MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;
   localparam logic [1:0] RESP_OKAY = 2'd0, RESP_SLVERR = 2'd2, RESP_DECERR = 2'd3;
   localparam logic [1:0] BURST_FIXED = 2'd0, BURST_WRAP = 2'd2, BURST_RSVD = 2'd3;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
      input logic [2:0] size, input logic [LEN_WIDTH-1:0] len, input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step, mask;
      step = ADDR_WIDTH'(1) << size;
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
         default:     next_addr = addr + step;
      endcase
   endfunction

   function automatic logic bad_req(input logic [2:0] size, input logic [LEN_WIDTH-1:0] len,
      input logic [1:0] burst);
      logic wrap_len_ok;
      wrap_len_ok = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                    (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
      bad_req = (burst == BURST_RSVD) || (size > 3'(BYTE_SHIFT)) ||
                ((burst == BURST_WRAP) && !wrap_len_ok);
   endfunction

   function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
      out_of_range = (addr >> BYTE_SHIFT) >= ADDR_WIDTH'(MEM_DEPTH);
   endfunction

   function automatic logic [MEM_AW-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] word;
      word = addr >> BYTE_SHIFT;
      word_index = word[MEM_AW-1:0];
   endfunction

   // ---------------- write channel ----------------
   logic [1:0]            w_state_reg, w_state_next;
   logic [ID_WIDTH-1:0]   wid_reg;
   logic [ADDR_WIDTH-1:0] waddr_reg;
   logic [LEN_WIDTH-1:0]  wlen_reg;
   logic [2:0]            wsize_reg;
   logic [1:0]            wburst_reg;
   logic [LEN_WIDTH:0]    wbeat_reg;
   logic                  wbad_reg, wdec_reg, wlast_err_reg;
   logic                  awready_reg, wready_reg, bvalid_reg;
   logic [1:0]            bresp_reg;
   logic                  aw_hs, w_hs, b_hs, w_in_burst, w_oor, w_last_err, mem_we;

   assign aw_hs      = awvalid & awready_reg;
   assign w_hs       = wvalid & wready_reg;
   assign b_hs       = bvalid_reg & bready;
   assign w_in_burst = wbeat_reg <= {1'b0, wlen_reg};
   assign w_oor      = out_of_range(waddr_reg);
   assign w_last_err = wlast != (wbeat_reg == {1'b0, wlen_reg});
   assign mem_we     = arstn & w_hs & w_in_burst & ~wbad_reg & ~w_oor;

   always_comb begin
      w_state_next = w_state_reg;
      case (w_state_reg)
         W_IDLE:  if (aw_hs) w_state_next = W_DATA;
         W_DATA:  if (w_hs && wlast) w_state_next = W_RESP;
         W_RESP:  if (b_hs) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!arstn) begin
         w_state_reg <= W_IDLE;
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
         wid_reg     <= '0;
      end else begin
         w_state_reg <= w_state_next;
         awready_reg <= (w_state_next == W_IDLE);
         wready_reg  <= (w_state_next == W_DATA);
         bvalid_reg  <= (w_state_next == W_RESP);
         if (aw_hs) begin
            wid_reg       <= awid;
            waddr_reg     <= awaddr;
            wlen_reg      <= awlen;
            wsize_reg     <= awsize;
            wburst_reg    <= awburst;
            wbeat_reg     <= '0;
            wbad_reg      <= bad_req(awsize, awlen, awburst);
            wdec_reg      <= 1'b0;
            wlast_err_reg <= 1'b0;
         end
         if (w_hs) begin
            // beats past len are drained without writing until wlast shows up
            if (w_in_burst) begin
               waddr_reg <= next_addr(waddr_reg, wsize_reg, wlen_reg, wburst_reg);
               wbeat_reg <= wbeat_reg + 1'b1;
               if (w_oor) wdec_reg <= 1'b1;
            end
            if (w_last_err) wlast_err_reg <= 1'b1;
            if (wlast) begin
               if (wbad_reg || wlast_err_reg || w_last_err) bresp_reg <= RESP_SLVERR;
               else if (wdec_reg || (w_in_burst && w_oor))  bresp_reg <= RESP_DECERR;
               else                                         bresp_reg <= RESP_OKAY;
            end
         end
      end
   end

   assign awready = awready_reg;
   assign wready  = wready_reg;
   assign bvalid  = bvalid_reg;
   assign bresp   = bresp_reg;
   assign bid     = wid_reg;

   // ---------------- read channel ----------------
   logic [0:0]            r_state_reg, r_state_next;
   logic [ID_WIDTH-1:0]   rid_reg;
   logic [ADDR_WIDTH-1:0] raddr_reg, rd_addr;
   logic [LEN_WIDTH-1:0]  rlen_reg, rbeat_reg, rd_beat, rd_len;
   logic [2:0]            rsize_reg;
   logic [1:0]            rburst_reg, rresp_reg;
   logic                  rbad_reg, rd_bad, rd_oor, rd_load;
   logic                  arready_reg, rvalid_reg, rlast_reg, ar_hs, r_hs;

   assign ar_hs   = arvalid & arready_reg;
   assign r_hs    = rvalid_reg & rready;
   assign rd_load = ar_hs | (r_hs & ~rlast_reg);

   // Beat 0 comes straight from the AR channel; later beats from the stored burst.
   always_comb begin
      rd_addr = next_addr(raddr_reg, rsize_reg, rlen_reg, rburst_reg);
      rd_beat = rbeat_reg + 1'b1;
      rd_len  = rlen_reg;
      rd_bad  = rbad_reg;
      if (r_state_reg == R_IDLE) begin
         rd_addr = araddr;
         rd_beat = '0;
         rd_len  = arlen;
         rd_bad  = bad_req(arsize, arlen, arburst);
      end
   end
   assign rd_oor = out_of_range(rd_addr);

   always_comb begin
      r_state_next = r_state_reg;
      case (r_state_reg)
         R_IDLE:  if (ar_hs) r_state_next = R_DATA;
         default: if (r_hs && rlast_reg) r_state_next = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!arstn) begin
         r_state_reg <= R_IDLE;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rlast_reg   <= 1'b0;
         rresp_reg   <= RESP_OKAY;
         rid_reg     <= '0;
      end else begin
         r_state_reg <= r_state_next;
         arready_reg <= (r_state_next == R_IDLE);
         rvalid_reg  <= (r_state_next == R_DATA);
         if (ar_hs) begin
            rid_reg    <= arid;
            rlen_reg   <= arlen;
            rsize_reg  <= arsize;
            rburst_reg <= arburst;
            rbad_reg   <= rd_bad;
         end
         if (rd_load) begin
            raddr_reg <= rd_addr;
            rbeat_reg <= rd_beat;
            rlast_reg <= (rd_beat == rd_len);
            rresp_reg <= rd_bad ? RESP_SLVERR : (rd_oor ? RESP_DECERR : RESP_OKAY);
         end
      end
   end

   assign arready = arready_reg;
   assign rvalid  = rvalid_reg;
   assign rlast   = rlast_reg;
   assign rresp   = rresp_reg;
   assign rid     = rid_reg;

   // ---------------- storage: one RAM per byte lane ----------------
   generate
      for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
         logic [7:0] lane_mem [MEM_DEPTH];
         logic [7:0] lane_q;

         always_ff @(posedge aclk) begin
            if (mem_we && wstrb[gi]) lane_mem[word_index(waddr_reg)] <= wdata[gi*8 +: 8];
         end

         // same-edge write leaves the old byte here, so reads see pre-write data
         always_ff @(posedge aclk) begin
            if (!arstn)       lane_q <= 8'h00;
            else if (rd_load) lane_q <= (rd_bad || rd_oor) ? 8'h00 : lane_mem[word_index(rd_addr)];
         end

         assign rdata[gi*8 +: 8] = lane_q;
      end
   endgenerate
endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized and directed bench for axi_slave_mem against a burst-level memory model.
module tb_axi_slave_mem;
   localparam int DW = 32, AW = 32, IW = 4, LW = 8, DEPTH = 1024;

   logic          aclk = 1'b0, arstn = 1'b0;
   logic [IW-1:0] awid, arid, bid, rid;
   logic [AW-1:0] awaddr, araddr;
   logic [LW-1:0] awlen, arlen;
   logic [2:0]    awsize, arsize;
   logic [1:0]    awburst, arburst, bresp, rresp;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;

   always #5 aclk = ~aclk;

   axi_slave_mem dut (
      .aclk(aclk), .arstn(arstn),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   int tests = 0, fails = 0;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] wq_data [$];
   logic [3:0]  wq_strb [$];
   logic [31:0] rd_q [$];
   logic [1:0]  rr_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit req_bad(input int size, input int len, input int burst);
      return (burst == 3) || ((1 << size) > DW / 8) ||
             ((burst == 2) && !(len inside {1, 3, 7, 15}));
   endfunction

   function automatic longint unsigned beat_addr(input longint unsigned addr, input int size,
      input int len, input int burst, input int i);
      longint unsigned nb, wrap, base;
      nb = longint'(1) << size;
      wrap = longint'(len + 1) * nb;
      if (burst == 0) return addr;
      if (burst == 2) begin
         base = (addr / wrap) * wrap;
         return base + ((addr - base + longint'(i) * nb) % wrap);
      end
      return addr + longint'(i) * nb;
   endfunction

   // Sends nsent beats (wlast on the last one) from wq_data/wq_strb.
   task automatic do_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
      input int len, input int size, input int burst, input int nsent, output logic [1:0] resp);
      bit bad, dec, got;
      int n;
      logic [1:0] exp_resp;
      longint unsigned a, w;
      bad = req_bad(size, len, burst);
      dec = 0;
      for (int i = 0; i < nsent && i <= len; i++) begin
         a = beat_addr(addr, size, len, burst, i);
         w = a >> 2;
         if (w >= DEPTH) dec = 1;
         else if (!bad)
            for (int b = 0; b < 4; b++)
               if (wq_strb[i][b]) model_mem[w][b*8 +: 8] = wq_data[i][b*8 +: 8];
      end
      exp_resp = (bad || nsent != len + 1) ? 2'd2 : (dec ? 2'd3 : 2'd0);
      resp = 2'bxx;

      awid = id; awaddr = addr; awlen = LW'(len); awsize = 3'(size); awburst = 2'(burst);
      awvalid = 1;
      n = 0;
      while (!awready && n < 100) begin @(negedge aclk); n++; end
      if (!awready) check({tag, " aw timeout"}, awready, 1);
      @(negedge aclk);
      awvalid = 0;

      for (int i = 0; i < nsent; i++) begin
         if ($urandom_range(0, 3) == 0) begin wvalid = 0; @(negedge aclk); end
         wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == nsent - 1); wvalid = 1;
         n = 0;
         while (!wready && n < 100) begin @(negedge aclk); n++; end
         if (!wready) check({tag, " w timeout"}, wready, 1);
         @(negedge aclk);
      end
      wvalid = 0; wlast = 0;

      got = 0;
      for (n = 0; n < 100 && !got; n++) begin
         bready = ($urandom_range(0, 2) != 0);
         if (bvalid && bready) begin
            check({tag, " bid"}, bid, id);
            check({tag, " bresp"}, bresp, exp_resp);
            resp = bresp;
            got = 1;
         end
         @(negedge aclk);
      end
      bready = 0;
      if (!got) check({tag, " b timeout"}, bvalid, 1);
      else      check({tag, " bvalid drop"}, bvalid, 0);
      $display("[TB] write %s addr=0x%0h len=%0d size=%0d burst=%0d beats=%0d bresp=%0d",
               tag, addr, len, size, burst, nsent, resp);
   endtask

   // Reads a burst; if stall_beat >= 0, rready is held low 5 cycles on that beat.
   task automatic do_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
      input int len, input int size, input int burst, input int stall_beat);
      bit bad, got;
      int n;
      longint unsigned a, w;
      logic [31:0] ed;
      logic [1:0] er;
      bad = req_bad(size, len, burst);
      rd_q.delete(); rr_q.delete();
      arid = id; araddr = addr; arlen = LW'(len); arsize = 3'(size); arburst = 2'(burst);
      arvalid = 1;
      n = 0;
      while (!arready && n < 100) begin @(negedge aclk); n++; end
      if (!arready) check({tag, " ar timeout"}, arready, 1);
      @(negedge aclk);
      arvalid = 0;

      for (int i = 0; i <= len; i++) begin
         a = beat_addr(addr, size, len, burst, i);
         w = a >> 2;
         if (bad)             begin ed = 0; er = 2; end
         else if (w >= DEPTH) begin ed = 0; er = 3; end
         else                 begin ed = model_mem[w]; er = 0; end
         if (i == stall_beat) begin
            rready = 0;
            n = 0;
            while (!rvalid && n < 100) begin @(negedge aclk); n++; end
            for (int s = 0; s < 5; s++) begin
               check({tag, " stall rvalid"}, rvalid, 1);
               check({tag, " stall rdata"}, rdata, ed);
               check({tag, " stall rlast"}, rlast, (i == len));
               @(negedge aclk);
            end
         end
         got = 0;
         for (n = 0; n < 100 && !got; n++) begin
            rready = (stall_beat >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (rvalid && rready) begin
               check({tag, " rdata"}, rdata, ed);
               check({tag, " rresp"}, rresp, er);
               check({tag, " rlast"}, rlast, (i == len));
               check({tag, " rid"}, rid, id);
               rd_q.push_back(rdata); rr_q.push_back(rresp);
               got = 1;
            end
            @(negedge aclk);
         end
         if (!got) check({tag, " r timeout"}, rvalid, 1);
      end
      rready = 0;
      check({tag, " rvalid end"}, rvalid, 0);
      $display("[TB] read  %s addr=0x%0h len=%0d size=%0d burst=%0d beats=%0d",
               tag, addr, len, size, burst, rd_q.size());
   endtask

   task automatic load_q(input int nb, input logic [31:0] base_val, input bit rnd);
      wq_data.delete(); wq_strb.delete();
      for (int i = 0; i < nb; i++) begin
         wq_data.push_back(rnd ? 32'($urandom) : base_val + 32'(i));
         wq_strb.push_back(4'hF);
      end
   endtask

   initial begin
      logic [1:0] resp;
      int burst, size, len, word, nsent;
      logic [31:0] addr;
      awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;

      repeat (3) @(negedge aclk);
      check("rst awready", awready, 0); check("rst wready", wready, 0);
      check("rst arready", arready, 0); check("rst bvalid", bvalid, 0);
      check("rst rvalid", rvalid, 0);   check("rst rlast", rlast, 0);
      check("rst bresp", bresp, 0);     check("rst rresp", rresp, 0);
      check("rst bid", bid, 0);         check("rst rid", rid, 0);
      check("rst rdata", rdata, 0);
      arstn = 1;
      @(negedge aclk);
      check("post-rst awready", awready, 1);
      check("post-rst arready", arready, 1);
      check("post-rst wready", wready, 0);

      // fill whole memory so the model is fully defined
      for (int k = 0; k < 4; k++) begin
         load_q(256, 0, 1);
         do_write("fill", 4'(k), 32'(k * 1024), 255, 2, 1, 256, resp);
      end

      load_q(4, 32'hA0, 0);
      do_write("incr", 4'h3, 32'h10, 3, 2, 1, 4, resp);
      check("incr bresp const", resp, 0);
      do_read("incr", 4'h5, 32'h10, 3, 2, 1, -1);
      for (int i = 0; i < 4; i++) check("incr rdata const", rd_q[i], 32'hA0 + 32'(i));

      load_q(4, 0, 0);
      for (int i = 0; i < 4; i++) wq_data[i] = 32'h30 + 32'(4 * i);
      do_write("wrapfill", 4'h1, 32'h30, 3, 2, 1, 4, resp);
      do_read("wrap", 4'h6, 32'h38, 3, 2, 2, -1);
      check("wrap b0", rd_q[0], 32'h38); check("wrap b1", rd_q[1], 32'h3C);
      check("wrap b2", rd_q[2], 32'h30); check("wrap b3", rd_q[3], 32'h34);

      load_q(1, 32'h12345678, 0);
      do_write("strb-pre", 4'h2, 32'h40, 0, 2, 1, 1, resp);
      load_q(1, 32'hFFFFFFFF, 0);
      wq_strb[0] = 4'h3;
      do_write("strb", 4'h2, 32'h40, 0, 2, 1, 1, resp);
      do_read("strb", 4'h2, 32'h40, 0, 2, 1, -1);
      check("strb merge const", rd_q[0], 32'h1234FFFF);

      load_q(1, 32'hDEADBEEF, 0);
      do_write("decerr", 4'h7, 32'(DEPTH * 4), 0, 2, 1, 1, resp);
      check("decerr bresp const", resp, 3);
      do_read("alias-w0", 4'h7, 32'h0, 0, 2, 1, -1);
      do_read("decerr", 4'h7, 32'(DEPTH * 4), 0, 2, 1, -1);
      check("decerr rresp const", rr_q[0], 3);
      check("decerr rdata const", rd_q[0], 0);

      load_q(2, 32'h55, 0);
      do_write("early-wlast", 4'h8, 32'h80, 3, 2, 1, 2, resp);
      check("early wlast bresp const", resp, 2);
      do_read("rsvd", 4'h9, 32'h80, 3, 2, 3, -1);
      for (int i = 0; i < 4; i++) check("rsvd rresp const", rr_q[i], 2);

      do_read("stall", 4'hA, 32'h100, 7, 2, 1, 3);

      for (int t = 0; t < 60; t++) begin
         int r;
         r = $urandom_range(0, 9);
         burst = (r == 0) ? 0 : (r <= 6) ? 1 : (r <= 8) ? 2 : 3;
         size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         if (burst == 2) begin
            r = $urandom_range(0, 4);
            len = (r == 0) ? 2 : (r == 1) ? 1 : (r == 2) ? 3 : (r == 3) ? 7 : 15;
         end else len = $urandom_range(0, 7);
         word = ($urandom_range(0, 6) == 0) ? DEPTH - $urandom_range(0, 4) : $urandom_range(0, DEPTH - 1);
         addr = 32'(word * 4) + (32'($urandom_range(0, 3)) & ~(32'((1 << size) - 1)) & 32'h3);
         if ($urandom_range(0, 1) == 0) begin
            nsent = len + 1;
            if ($urandom_range(0, 6) == 0) nsent = (len > 0 && $urandom_range(0, 1) == 0) ? len : len + 2;
            wq_data.delete(); wq_strb.delete();
            for (int i = 0; i < nsent; i++) begin
               wq_data.push_back(32'($urandom));
               wq_strb.push_back(4'($urandom));
            end
            do_write("rand", 4'($urandom), addr, len, size, burst, nsent, resp);
         end else begin
            do_read("rand", 4'($urandom), addr, len, size, burst, -1);
         end
      end

      // reset pulse in the middle of a read burst
      arid = 4'hB; araddr = 32'h200; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1;
      while (!arready) @(negedge aclk);
      @(negedge aclk);
      arvalid = 0; rready = 1;
      check("midrst beat0", rdata, model_mem[32'h200 >> 2]);
      @(negedge aclk);
      @(negedge aclk);
      rready = 0; arstn = 0;
      @(negedge aclk);
      check("midrst rvalid", rvalid, 0); check("midrst arready", arready, 0);
      check("midrst rdata", rdata, 0);   check("midrst rid", rid, 0);
      arstn = 1;
      @(negedge aclk);
      check("midrst arready after", arready, 1);
      check("midrst awready after", awready, 1);
      check("midrst rvalid after", rvalid, 0);
      $display("[TB] reset pulse mid-read done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameters SHALL be exactly as follows; all widths below derive from them.
- DATA_WIDTH, default 32: data bus width in bits; a power of two, at least 8.
- ADDR_WIDTH, default 32: address width in bits.
- ID_WIDTH, default 4: transaction ID width in bits.
- LEN_WIDTH, default 8: burst-length field width (beats = len+1).
- MEM_DEPTH, default 1024: memory size in DATA_WIDTH words.
REQ-002 One clock, aclk; reset arstn is synchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- aclk  in  1  clock
- arstn  in  1  synchronous active-low reset
- awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH/3/2  write address channel
- awvalid  in  1;  awready  out  1
- wdata  in  DATA_WIDTH;  wstrb  in  DATA_WIDTH/8;  wlast  in  1
- wvalid  in  1;  wready  out  1
- bid  out  ID_WIDTH;  bresp  out  2
- bvalid  out  1;  bready  in  1
- arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH/3/2  read address channel
- arvalid  in  1;  arready  out  1
- rid  out  ID_WIDTH;  rdata  out  DATA_WIDTH;  rresp  out  2;  rlast  out  1
- rvalid  out  1;  rready  in  1
REQ-004 Encodings SHALL be: burst 0 FIXED, 1 INCR, 2 WRAP, 3 reserved; response 0 OKAY, 2 SLVERR, 3 DECERR.

Function
REQ-005 A transfer SHALL occur on any rising aclk edge where valid and ready are both high.
REQ-006 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP.
- W_IDLE: awready=1. AW handshake latches id/addr/len/size/burst, clears the beat counter, moves to W_DATA.
- W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb to word addr>>log2(DATA_WIDTH/8), then advances the address.
- The W handshake with wlast=1 moves to W_RESP.
- W_RESP: bvalid=1, bid = latched id. The B handshake returns to W_IDLE.
REQ-007 Read FSM states SHALL be R_IDLE and R_DATA.
- R_IDLE: arready=1. AR handshake latches the request and registers beat 0 into rdata/rresp/rlast; rvalid rises the next cycle.
- R_DATA: each R handshake registers the next beat on the same edge, so back-to-back beats are possible.
- The R handshake with rlast=1 returns to R_IDLE.
REQ-008 Read and write FSMs SHALL run independently and concurrently; there is one outstanding transaction per direction.
REQ-009 Address advance per beat SHALL be:
- FIXED: unchanged.
- INCR: +(1<<size).
- WRAP: +(1<<size) within a (len+1)*(1<<size) aligned window, wrapping to the window base.
REQ-010 A read and a write to the same word on the same edge SHALL return the pre-write content in rdata.
REQ-011 SLVERR SHALL be raised when:
- burst=3; or
- (1<<size) > DATA_WIDTH/8; or
- WRAP with len not in {1,3,7,15}.
Effect: write data is discarded; read beats return rdata=0. The beat count and handshakes are unchanged.
REQ-012 DECERR SHALL be raised when a beat's word index is >= MEM_DEPTH.
- Write: that beat is suppressed.
- Read: that beat returns rdata=0 and rresp=3.
- Write response: bresp=3 if any beat decoded out of range.
REQ-013 bresp SHALL be SLVERR if wlast arrives on a beat count other than len, or if it is absent at beat len.
- If wlast is absent, writing stops after beat len and W_DATA continues accepting beats until wlast.
- Response priority is SLVERR > DECERR > OKAY.
REQ-014 rlast SHALL be high exactly on beat len; rid equals the latched arid on every beat.
REQ-015 bvalid/rvalid, once high, SHALL hold with stable payload until their handshake completes.

Reset
REQ-016 While arstn=0 at an aclk edge:
- Both FSMs go to idle.
- awready=0, wready=0, arready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0.
- Memory contents are undefined and not cleared.
REQ-017 Reset asserted mid-burst SHALL abandon the transaction with no response issued.
REQ-018 awready and arready SHALL be 1 on the first edge after arstn returns to 1.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- INCR write: addr 0x10, len 3, size 2, wdata 0xA0..0xA3, wstrb 0xF -> bresp 0. Read of the same burst -> rdata 0xA0..0xA3, rlast only on beat 3, rresp 0.
- WRAP read: addr 0x38, len 3, size 2, after INCR fill of 0x30..0x3C -> beat addresses 0x38, 0x3C, 0x30, 0x34.
- wstrb=0x3, wdata 0xFFFFFFFF over a word holding 0x12345678 -> readback 0x1234FFFF.
- Write to word MEM_DEPTH -> bresp 3, memory unchanged. Read of the same address -> rresp 3, rdata 0.
- wlast on beat 1 of a len-3 burst -> bresp 2. burst=3 read -> all beats rresp 2.
- rready held low for 5 cycles mid-burst -> rvalid/rdata stable. Reset pulse mid-read -> rvalid 0 next edge, arready 1 after release.
